pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_gen.sv | 91 +++++++++
 tb/tb_pc_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: next-PC source
// encoding, default vectors and the fixed-priority source selector.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    JUMP   = 3'd1,
    RET    = 3'd2,
    BRANCH = 3'd3,
    TRAP   = 3'd4
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEF_PC_INC       = 4;
  localparam int          DEF_RAS_DEPTH    = 4;

  // Fixed priority: trap > branch > return > jump/call > sequential.
  function automatic pc_src_e select_src(input logic trap,
                                         input logic branch_taken,
                                         input logic ret,
                                         input logic jump);
    if (trap)              return TRAP;
    else if (branch_taken) return BRANCH;
    else if (ret)          return RET;
    else if (jump)         return JUMP;
    else                   return SEQ;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack. Circular buffer: pushing while full overwrites the
// oldest entry, so the most recent RAS_DEPTH return addresses survive.
// A replace on an empty stack degrades to a push.
module pc_ras
  import pc_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               replace,
  input  logic [NB_DATA-1:0] data,
  output logic [NB_DATA-1:0] top,
  output logic               empty,
  output logic               full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ras: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [NB_DATA-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]      ptr;      // next free slot; top lives at ptr-1
  logic [CW-1:0]      count;
  logic [PW-1:0]      top_idx;
  logic               do_push;
  logic               do_pop;
  logic               do_replace;

  assign top_idx    = ptr - PW'(1);
  assign top        = mem[top_idx];
  assign empty      = (count == '0);
  assign full       = (count == CW'(RAS_DEPTH));
  assign do_push    = push | (replace & empty);
  assign do_replace = replace & ~empty;
  assign do_pop     = pop & ~empty;

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push)         mem[ptr]     <= data;
    else if (do_replace) mem[top_idx] <= data;
  end

  // Pointer and occupancy; count saturates at RAS_DEPTH on overwrite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with trap, branch, jump/call and return sources
// and a small return-address stack. Trap overrides stall; every other source
// only takes effect when i_PCwrite is high.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                 NB_DATA      = 32,
  parameter logic [NB_DATA-1:0] RESET_VECTOR = NB_DATA'(DEF_RESET_VECTOR),
  parameter logic [NB_DATA-1:0] TRAP_VECTOR  = NB_DATA'(DEF_TRAP_VECTOR),
  parameter int                 PC_INC       = DEF_PC_INC,
  parameter int                 RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_PCwrite,
  input  logic               i_trap,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic [NB_DATA-1:0] i_jump_target,
  output logic [NB_DATA-1:0] o_PC,
  output logic [NB_DATA-1:0] o_PC_plus,
  output logic               o_ras_empty,
  output logic               o_ras_full,
  output logic               o_ras_underflow
);

  pc_src_e            src;
  logic [NB_DATA-1:0] next_pc;
  logic [NB_DATA-1:0] ras_top;
  logic               update;
  logic               call_q;
  logic               ret_sel;
  logic               jump_sel;
  logic               ras_push;
  logic               ras_pop;
  logic               ras_replace;
  logic               underflow_next;

  assign o_PC_plus = o_PC + NB_DATA'(PC_INC);

  // Source selection, stack control and next-PC mux.
  always_comb begin
    src            = select_src(i_trap, i_branch_taken, i_ret, i_jump);
    update         = i_trap | i_PCwrite;
    call_q         = i_jump & i_call;
    ret_sel        = i_PCwrite & (src == RET);
    jump_sel       = i_PCwrite & (src == JUMP);
    ras_push       = jump_sel & i_call;
    ras_pop        = ret_sel & ~call_q;
    ras_replace    = ret_sel & call_q;
    underflow_next = ret_sel & o_ras_empty;
    next_pc        = o_PC_plus;
    case (src)
      TRAP:    next_pc = TRAP_VECTOR;
      BRANCH:  next_pc = i_branch_target;
      RET:     next_pc = o_ras_empty ? o_PC_plus : ras_top;
      JUMP:    next_pc = i_jump_target;
      default: next_pc = o_PC_plus;
    endcase
  end

  // PC register and the one-cycle underflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_PC            <= RESET_VECTOR;
      o_ras_underflow <= 1'b0;
    end else begin
      o_ras_underflow <= underflow_next;
      if (update) o_PC <= next_pc;
    end
  end

  pc_ras #(
    .NB_DATA   (NB_DATA),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (i_clk),
    .reset   (i_reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .data    (o_PC_plus),
    .top     (ras_top),
    .empty   (o_ras_empty),
    .full    (o_ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the PC and stack.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcw, trap, br, jmp, call, ret;
  logic [31:0] bt, jt;
  logic [31:0] pc, pc_plus;
  logic        empty, full, uf;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_uf;

  always #5 clk = ~clk;

  pc_gen dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_PCwrite       (pcw),
    .i_trap          (trap),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_jump          (jmp),
    .i_call          (call),
    .i_ret           (ret),
    .i_jump_target   (jt),
    .o_PC            (pc),
    .o_PC_plus       (pc_plus),
    .o_ras_empty     (empty),
    .o_ras_full      (full),
    .o_ras_underflow (uf)
  );

  task automatic set_idle();
    pcw = 0; trap = 0; br = 0; jmp = 0; call = 0; ret = 0;
    bt = '0; jt = '0;
  endtask

  task automatic m_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_uf = 0;
  endtask

  // Advance the reference model from the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] plus;
    plus = m_pc + 32'd4;
    m_uf = 0;
    if (trap) begin
      m_pc = 32'h100;
    end else if (pcw) begin
      if (br) begin
        m_pc = bt;
      end else if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc = plus;
          m_uf = 1;
        end else begin
          m_pc = m_stack.pop_back();
        end
        if (jmp && call) m_stack.push_back(plus);
      end else if (jmp) begin
        m_pc = jt;
        if (call) begin
          if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
          m_stack.push_back(plus);
        end
      end else begin
        m_pc = plus;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    m_reset();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc_async: got %h expected %h", pc, 32'h0); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (pc_plus !== 32'h4) begin errors++; $display("FAIL reset_pc_plus: got %h expected %h", pc_plus, 32'h4); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", uf); end
    #3 rst = 0;
  endtask

  task automatic test_sequential();
    set_idle();
    pcw = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_call_return();
    set_idle(); pcw = 1; jmp = 1; jt = 32'h10;
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL cr_jump: got %h expected %h", pc, 32'h10); end
    call = 1; jt = 32'h200;
    tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL cr_call: got %h expected %h", pc, 32'h200); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL cr_not_empty: got %b expected 0", empty); end
    jmp = 0; call = 0;
    tick();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL cr_step1: got %h expected %h", pc, 32'h204); end
    tick();
    checks++; if (pc !== 32'h208) begin errors++; $display("FAIL cr_step2: got %h expected %h", pc, 32'h208); end
    ret = 1;
    tick();
    ret = 0;
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL cr_ret: got %h expected %h", pc, 32'h14); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cr_empty_after: got %b expected 1", empty); end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL cr_underflow: got %b expected 0", uf); end
  endtask

  task automatic test_overflow();
    logic [31:0] ra [5];
    set_idle(); pcw = 1;
    ra[0] = 32'h18;
    for (int i = 1; i < 5; i++) ra[i] = 32'h1000 * i + 32'h4;
    jmp = 1; call = 1;
    for (int i = 1; i <= 5; i++) begin
      jt = 32'h1000 * i;
      tick();
      checks++; if (pc !== 32'h1000 * i) begin errors++; $display("FAIL ovf_call[%0d]: got %h expected %h", i, pc, 32'h1000 * i); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    jmp = 0; call = 0; ret = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (pc !== ra[4 - k]) begin errors++; $display("FAIL ovf_pop[%0d]: got %h expected %h", k, pc, ra[4 - k]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
    tick();
    checks++; if (pc !== 32'h1008) begin errors++; $display("FAIL ovf_underflow_pc: got %h expected %h", pc, 32'h1008); end
    checks++; if (uf !== 1'b1) begin errors++; $display("FAIL ovf_underflow_pulse: got %b expected 1", uf); end
    ret = 0;
    tick();
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL ovf_underflow_clear: got %b expected 0", uf); end
    checks++; if (pc !== 32'h100C) begin errors++; $display("FAIL ovf_after: got %h expected %h", pc, 32'h100C); end
  endtask

  task automatic test_priority();
    set_idle(); pcw = 1; jmp = 1; call = 1; jt = 32'h300;
    tick();
    set_idle(); trap = 1; br = 1; bt = 32'h500; ret = 1;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL prio_trap_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL prio_stack_kept: got %b expected 0", empty); end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL prio_underflow: got %b expected 0", uf); end
    set_idle(); pcw = 1; ret = 1;
    tick();
    checks++; if (pc !== 32'h1010) begin errors++; $display("FAIL prio_ret_after: got %h expected %h", pc, 32'h1010); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL prio_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_stall();
    set_idle(); pcw = 1; jmp = 1; call = 1; jt = 32'h400;
    tick();
    set_idle(); ret = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h400) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h400); end
      checks++; if (uf !== 1'b0) begin errors++; $display("FAIL stall_underflow[%0d]: got %b expected 0", i, uf); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL stall_empty[%0d]: got %b expected 0", i, empty); end
    end
    pcw = 1;
    tick();
    checks++; if (pc !== 32'h1014) begin errors++; $display("FAIL stall_release: got %h expected %h", pc, 32'h1014); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stall_release_empty: got %b expected 1", empty); end
  endtask

  task automatic test_wrap_reset();
    set_idle(); pcw = 1; jmp = 1; jt = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_plus: got %h expected %h", pc_plus, 32'h0); end
    jmp = 0;
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
    jmp = 1; call = 1; jt = 32'h800;
    tick();
    jt = 32'h900;
    #2 rst = 1;
    m_reset();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty: got %b expected 1", empty); end
    @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc: got %h expected %h", pc, 32'h0); end
    #3 rst = 0;
    set_idle(); pcw = 1;
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc: got %h expected %h", pc, 32'h4); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b expected 1", empty); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      pcw  = ($urandom_range(0, 9) != 0);
      trap = ($urandom_range(0, 19) == 0);
      br   = ($urandom_range(0, 7) == 0);
      bt   = $urandom & 32'hFFFF_FFFC;
      jmp  = ($urandom_range(0, 3) == 0);
      call = $urandom_range(0, 1) != 0;
      ret  = ($urandom_range(0, 4) == 0);
      jt   = $urandom & 32'hFFFF_FFFC;
      if (ret && call) jmp = 1;
      if (ret && call && m_stack.size() == 0) call = 0;
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", n, pc, m_pc); end
      checks++; if (pc_plus !== m_pc + 32'd4) begin errors++; $display("FAIL rand_plus[%0d]: got %h expected %h", n, pc_plus, m_pc + 32'd4); end
      checks++; if (empty !== (m_stack.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d]: got %b expected %b", n, empty, m_stack.size() == 0); end
      checks++; if (full !== (m_stack.size() == DEPTH)) begin errors++; $display("FAIL rand_full[%0d]: got %b expected %b", n, full, m_stack.size() == DEPTH); end
      checks++; if (uf !== m_uf) begin errors++; $display("FAIL rand_underflow[%0d]: got %b expected %b", n, uf, m_uf); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow();
    test_priority();
    test_stall();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
